// File: rtl/debug_tx_queue_pkg.sv
// Shared types and defaults for the debug transmit queue.
package debug_tx_queue_pkg;

  // Pacing FSM states
  typedef enum logic [2:0] {
    IDLE,
    SEND,
    WAIT_ACK,
    WAIT_DONE,
    GAP
  } debug_tx_state_t;

  localparam int DEBUG_TX_DEPTH = 16;

  // Counter width that stays at least one bit for tiny parameter values
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val);
  endfunction

endpackage

// File: rtl/debug_tx_queue_byte_fifo.sv
// Circular byte FIFO with occupancy, flush and sticky overflow flag.
module byte_fifo
  import debug_tx_queue_pkg::*;
#(
  parameter int DEPTH = DEBUG_TX_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [7:0]               wr_data,
  input  logic                     rd_en,
  input  logic                     flush,
  input  logic                     overflow_clr,
  output logic [7:0]               rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          overflow_q, overflow_d;
  logic [7:0]    mem_q [DEPTH];
  logic          push;
  logic          pop;

  // The extra pointer MSB separates a full buffer from an empty one
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign level    = wr_ptr_q - rd_ptr_q;
  assign overflow = overflow_q;
  assign rd_data  = mem_q[rd_ptr_q[AW-1:0]];

  // A pop in the same cycle frees a slot, so a push into a full FIFO may still land
  assign pop  = rd_en && !empty;
  assign push = wr_en && !flush && (!full || pop);

  // Next pointer and overflow computation; flush drops any same-cycle push silently
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q && !overflow_clr;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (flush) rd_ptr_d = wr_ptr_q;
    else if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
    if (wr_en && !flush && !push) overflow_d = 1'b1;
  end

  // Pointer and flag registers
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
    end
  end

  // Byte storage, written on accepted pushes only
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/debug_tx_queue.sv
// Debug byte queue that paces one send strobe per byte toward the UART.
module debug_tx_queue
  import debug_tx_queue_pkg::*;
#(
  parameter int DEPTH       = DEBUG_TX_DEPTH,
  parameter int GAP_CYCLES  = 16,
  parameter int ACK_TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [7:0]             wr_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  input  logic                   overflow_clr,
  input  logic                   flush,
  input  logic                   tx_busy,
  output logic                   debug_send,
  output logic [7:0]             debug_data
);

  localparam int TW = cnt_width(ACK_TIMEOUT);
  localparam int GW = cnt_width(GAP_CYCLES);
  localparam logic [TW-1:0] ACK_LAST = TW'(ACK_TIMEOUT - 1);
  // The cycle that leaves WAIT_DONE/WAIT_ACK and the IDLE decision cycle are
  // both idle line time, so GAP itself dwells GAP_CYCLES-1 clocks (at least one).
  localparam logic [GW-1:0] GAP_LOAD = GW'((GAP_CYCLES >= 2) ? GAP_CYCLES - 2 : 0);

  debug_tx_state_t state_q, state_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic [7:0]      data_q, data_d;
  logic            send_q, send_d;
  logic            pop;
  logic [7:0]      head;

  byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk          (clk),
    .reset        (reset),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .rd_en        (pop),
    .flush        (flush),
    .overflow_clr (overflow_clr),
    .rd_data      (head),
    .full         (full),
    .empty        (empty),
    .level        (level),
    .overflow     (overflow)
  );

  assign debug_send = send_q;
  assign debug_data = data_q;

  // Pacing FSM: next state, counters, pop request and registered strobe/data
  always_comb begin
    state_d = state_q;
    tmo_d   = tmo_q;
    gap_d   = gap_q;
    data_d  = data_q;
    send_d  = 1'b0;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty && !tx_busy) begin
          pop     = 1'b1;
          data_d  = head;
          send_d  = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        tmo_d   = '0;
        state_d = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (tx_busy) begin
          state_d = WAIT_DONE;
        end else if (tmo_q == ACK_LAST) begin
          gap_d   = GAP_LOAD;
          state_d = GAP;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          gap_d   = GAP_LOAD;
          state_d = GAP;
        end
      end
      GAP: begin
        if (gap_q == '0) state_d = IDLE;
        else gap_d = gap_q - GW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state, counters and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      tmo_q   <= '0;
      gap_q   <= '0;
      data_q  <= 8'h00;
      send_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      gap_q   <= gap_d;
      data_q  <= data_d;
      send_q  <= send_d;
    end
  end

endmodule

// File: tb/tb_debug_tx_queue.sv
// Directed bench for debug_tx_queue with a simple UART busy model.
module tb_debug_tx_queue;
  import debug_tx_queue_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       full, empty, overflow, debug_send;
  logic [4:0] level;
  logic       overflow_clr = 1'b0;
  logic       flush = 1'b0;
  logic       tx_busy;
  logic [7:0] debug_data;

  logic       busy_hold = 1'b0;
  logic       busy_en = 1'b0;
  int         busy_cnt = 0;
  int         cyc = 0;
  int         n_chk = 0;
  int         n_pass = 0;
  logic       prev_send = 1'b0;
  int         st_cyc[$];
  logic [7:0] st_dat[$];

  debug_tx_queue #(.DEPTH(16), .GAP_CYCLES(16), .ACK_TIMEOUT(64)) dut (
    .clk          (clk),
    .reset        (reset),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .full         (full),
    .empty        (empty),
    .level        (level),
    .overflow     (overflow),
    .overflow_clr (overflow_clr),
    .flush        (flush),
    .tx_busy      (tx_busy),
    .debug_send   (debug_send),
    .debug_data   (debug_data)
  );

  always #5 clk = ~clk;

  // UART model: busy for 10 clocks starting the cycle after each strobe
  assign tx_busy = busy_hold | (busy_en & (busy_cnt != 0));
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (debug_send) busy_cnt <= 10;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Strobe monitor: log every strobe and make sure none lasts two cycles
  always @(negedge clk) begin
    if (debug_send) begin
      check("strobe_width", {31'd0, prev_send}, 32'd0);
      st_cyc.push_back(cyc);
      st_dat.push_back(debug_data);
    end
    prev_send <= debug_send;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    st_cyc.delete();
    st_dat.delete();
  endtask

  task automatic push(input logic [7:0] b);
    wr_en = 1'b1;
    wr_data = b;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic wait_strobes(input int n, input int budget);
    int k = 0;
    while (st_cyc.size() < n && k < budget) begin
      tick();
      k++;
    end
    if (st_cyc.size() < n) check("strobe_wait", st_cyc.size(), n);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;

    // Reset state
    do_reset();
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_level", level, 0);
    check("rst_ovf", overflow, 0);
    check("rst_send", debug_send, 0);
    check("rst_data", debug_data, 8'h00);

    // Three bytes, busy model 10 clocks, gap 16 -> 28-clock period
    busy_en = 1'b1;
    c0 = cyc;
    push(8'h44);
    push(8'h42);
    push(8'h47);
    wait_strobes(3, 200);
    if (st_cyc.size() >= 3) begin
      check("t1_lat", st_cyc[0] - c0, 2);
      check("t1_d0", st_dat[0], 8'h44);
      check("t1_d1", st_dat[1], 8'h42);
      check("t1_d2", st_dat[2], 8'h47);
      check("t1_per01", st_cyc[1] - st_cyc[0], 28);
      check("t1_per12", st_cyc[2] - st_cyc[1], 28);
    end
    repeat (40) tick();
    check("t1_count", st_cyc.size(), 3);
    check("t1_hold", debug_data, 8'h47);
    check("t1_empty", empty, 1);

    // Fill to overflow while UART is held busy
    do_reset();
    busy_hold = 1'b1;
    for (int i = 0; i < 17; i++) begin
      if (i == 16) begin
        check("t2_full", full, 1);
        check("t2_lvl16", level, 16);
        check("t2_ovf_pre", overflow, 0);
        overflow_clr = 1'b1;
      end
      push(i[7:0]);
    end
    overflow_clr = 1'b0;
    check("t2_ovf_set_wins", overflow, 1);
    check("t2_lvl_after", level, 16);
    check("t2_no_strobe", st_cyc.size(), 0);
    overflow_clr = 1'b1;
    tick();
    overflow_clr = 1'b0;
    check("t2_ovf_clr", overflow, 0);

    // Push into a full FIFO in the same cycle as the pop
    busy_hold = 1'b0;
    push(8'hA5);
    check("t4_lvl", level, 16);
    check("t4_full", full, 1);
    check("t4_ovf", overflow, 0);
    wait_strobes(17, 700);
    if (st_cyc.size() >= 17) begin
      for (int i = 0; i < 16; i++) check($sformatf("t2_d%0d", i), st_dat[i], i);
      check("t4_d16", st_dat[16], 8'hA5);
    end
    check("t2_empty", empty, 1);

    // UART never acknowledges: timeout then gap
    do_reset();
    busy_en = 1'b0;
    push(8'h11);
    push(8'h22);
    wait_strobes(2, 200);
    if (st_cyc.size() >= 2) begin
      check("t3_d0", st_dat[0], 8'h11);
      check("t3_d1", st_dat[1], 8'h22);
      check("t3_per", st_cyc[1] - st_cyc[0], 81);
    end

    // Flush while the first byte is in flight
    repeat (100) tick();
    do_reset();
    busy_en = 1'b1;
    for (int i = 0; i < 5; i++) push(8'h61 + i[7:0]);
    wait_strobes(1, 20);
    repeat (4) tick();
    check("t5_lvl_pre", level, 4);
    flush = 1'b1;
    wr_en = 1'b1;
    wr_data = 8'h99;
    tick();
    flush = 1'b0;
    wr_en = 1'b0;
    check("t5_lvl", level, 0);
    check("t5_empty", empty, 1);
    check("t5_ovf", overflow, 0);
    repeat (120) tick();
    check("t5_count", st_cyc.size(), 1);
    if (st_cyc.size() >= 1) check("t5_d0", st_dat[0], 8'h61);

    // Reset during WAIT_DONE with bytes still queued
    do_reset();
    for (int i = 0; i < 4; i++) push(8'h31 + i[7:0]);
    wait_strobes(1, 20);
    repeat (5) tick();
    check("t6_lvl_pre", level, 3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t6_send", debug_send, 0);
    check("t6_data", debug_data, 8'h00);
    check("t6_empty", empty, 1);
    check("t6_level", level, 0);
    check("t6_full", full, 0);
    check("t6_ovf", overflow, 0);
    st_cyc.delete();
    st_dat.delete();
    repeat (60) tick();
    check("t6_quiet", st_cyc.size(), 0);
    c0 = cyc;
    push(8'h77);
    wait_strobes(1, 20);
    if (st_cyc.size() >= 1) begin
      check("t6_new_lat", st_cyc[0] - c0, 2);
      check("t6_new_d", st_dat[0], 8'h77);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
